dmem_resp: RTL and testbench

Memory-side responder for the CPU data port: services the M-stage load/store request that the datapath drives (address, write data, write enable, byte strobes) and returns read data. It models a single-port word SRAM with a configurable number of wait states. While an access is in flight it raises a stall to the hazard unit, so the pipeline tolerates slow memory. It sits between the datapath's memory stage and the data RAM, in place of a zero-latency ideal memory.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_sram_array.sv | 35 +++
 rtl/dmem_resp.sv | 130 +++++++++++++
 tb/tb_dmem_resp.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Byte-strobe encodings are offered to callers building store requests.
package dmem_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAccess,
      StResp
   } dmem_state_e;

   localparam logic [3:0] WSTRB_BYTE0   = 4'b0001;
   localparam logic [3:0] WSTRB_BYTE1   = 4'b0010;
   localparam logic [3:0] WSTRB_BYTE2   = 4'b0100;
   localparam logic [3:0] WSTRB_BYTE3   = 4'b1000;
   localparam logic [3:0] WSTRB_HALF_LO = 4'b0011;
   localparam logic [3:0] WSTRB_HALF_HI = 4'b1100;
   localparam logic [3:0] WSTRB_WORD    = 4'b1111;

   localparam int unsigned WCNT_W = 3;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
// Contents and the read register are deliberately left without reset.
module dmem_sram_array #(
   parameter int unsigned Depth = 1024,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [AddrW-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [Depth];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) begin
                  mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// M-stage data memory responder: latches one request, inserts WAIT cycles,
// performs the array access and returns a one-cycle response while stalling the CPU.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic        req_we,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   output logic        resp_valid,
   output logic        addr_err,
   output logic        stall_mem
);

   localparam int unsigned AW = $clog2(DEPTH);

   dmem_state_e       state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              we_q, we_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic              oob_q, oob_d;
   logic              rzero_q, rzero_d;
   logic              req_oob;
   logic              arr_en;
   logic [31:0]       arr_rdata;
   logic              unused_addr;

   assign unused_addr = ^req_addr[1:0];
   assign req_oob     = (req_addr[31:2] >= 30'(DEPTH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (req_en) state_d = (WAIT != 0) ? StWait : StAccess;
         StWait:   if (wcnt_q == WCNT_W'(1)) state_d = StAccess;
         StAccess: state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      resp_valid = (state_q == StResp);
      addr_err   = (state_q == StResp) && oob_q;
      stall_mem  = rst && (((state_q == StIdle) && req_en) || (state_q == StWait) ||
                           (state_q == StAccess));
      arr_en     = (state_q == StAccess) && !oob_q;
      // Read register is not reset, so a flag forces zero after reset or an oob access.
      rdata      = rzero_q ? '0 : arr_rdata;
   end

   always_comb begin
      wcnt_d  = wcnt_q;
      we_d    = we_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      oob_d   = oob_q;
      rzero_d = rzero_q;
      if ((state_q == StIdle) && req_en) begin
         we_d    = req_we;
         wstrb_d = req_wstrb;
         wdata_d = req_wdata;
         idx_d   = req_addr[AW+1:2];
         oob_d   = req_oob;
         wcnt_d  = WCNT_W'(WAIT);
      end
      if (state_q == StWait) begin
         wcnt_d = wcnt_q - WCNT_W'(1);
      end
      if (state_q == StAccess) begin
         if (oob_q) begin
            rzero_d = 1'b1;
         end else if (!we_q) begin
            rzero_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         wstrb_q <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
         oob_q   <= 1'b0;
         rzero_q <= 1'b1;
      end else begin
         wcnt_q  <= wcnt_d;
         we_q    <= we_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         oob_q   <= oob_d;
         rzero_q <= rzero_d;
      end
   end

   dmem_sram_array #(
      .Depth (DEPTH),
      .AddrW (AW)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (we_q),
      .be    (wstrb_q),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance with WAIT=2, one with WAIT=0,
// sharing request fields but with separate enables.
module tb_dmem_resp;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_en_a, req_en_b, req_we;
   logic [3:0]  req_wstrb;
   logic [31:0] req_addr, req_wdata;
   logic [31:0] rdata_a, rdata_b;
   logic        resp_valid_a, resp_valid_b, addr_err_a, addr_err_b, stall_a, stall_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_resp #(.DEPTH(1024), .WAIT(2)) u_dut (
      .clk (clk), .rst (rst), .req_en (req_en_a), .req_we (req_we), .req_wstrb (req_wstrb),
      .req_addr (req_addr), .req_wdata (req_wdata), .rdata (rdata_a),
      .resp_valid (resp_valid_a), .addr_err (addr_err_a), .stall_mem (stall_a)
   );

   dmem_resp #(.DEPTH(1024), .WAIT(0)) u_dut0 (
      .clk (clk), .rst (rst), .req_en (req_en_b), .req_we (req_we), .req_wstrb (req_wstrb),
      .req_addr (req_addr), .req_wdata (req_wdata), .rdata (rdata_b),
      .resp_valid (resp_valid_b), .addr_err (addr_err_b), .stall_mem (stall_b)
   );

   // Issue one request at posedge+1 and follow it to its response (bounded).
   task automatic access(input bit sel_b, input logic we, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata, output int rc,
                         output logic [15:0] sh, output logic [31:0] rd, output logic err);
      req_we = we; req_wstrb = strb; req_addr = addr; req_wdata = wdata;
      if (sel_b) req_en_b = 1'b1; else req_en_a = 1'b1;
      rc = -1; sh = '0; rd = '0; err = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         sh[k] = sel_b ? stall_b : stall_a;
         if (sel_b ? resp_valid_b : resp_valid_a) begin
            rc  = k;
            rd  = sel_b ? rdata_b : rdata_a;
            err = sel_b ? addr_err_b : addr_err_a;
         end
         @(posedge clk); #1;
         if (rc >= 0) break;
      end
      req_en_a = 1'b0; req_en_b = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; req_en_a = 1'b1; req_en_b = 1'b0; req_we = 1'b0;
      req_wstrb = '0; req_addr = '0; req_wdata = '0;
      #12;
      n_cmp++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_a); end
      n_cmp++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata_a); end
      n_cmp++; if (resp_valid_a !== 1'b0 || addr_err_a !== 1'b0) begin
         n_fail++; $display("FAIL rst_resp: got %b%b want 00", resp_valid_a, addr_err_a); end
      req_en_a = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      int rc; logic [15:0] sh; logic [31:0] rd; logic err;
      access(0, 1'b1, WSTRB_WORD, 32'h10, 32'hDEADBEEF, rc, sh, rd, err);
      n_cmp++; if (rc !== 4) begin n_fail++; $display("FAIL word_st_lat: got %0d want 4", rc); end
      n_cmp++; if (sh !== 16'h000F) begin n_fail++; $display("FAIL word_st_stall: got %h want 000f", sh); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL word_st_err: got %b want 0", err); end
      access(0, 1'b0, 4'h0, 32'h10, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rc !== 4) begin n_fail++; $display("FAIL word_ld_lat: got %0d want 4", rc); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_ld_data: got %h want deadbeef", rd); end
      @(negedge clk);
      n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_hold: got %h want deadbeef", rdata_a); end
      @(posedge clk); #1;
   endtask

   task automatic test_lanes();
      int rc; logic [15:0] sh; logic [31:0] rd; logic err;
      access(0, 1'b1, WSTRB_WORD, 32'h20, 32'h11223344, rc, sh, rd, err);
      access(0, 1'b1, WSTRB_BYTE1, 32'h20, 32'h0000AA00, rc, sh, rd, err);
      access(0, 1'b0, 4'h0, 32'h20, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL lane_byte1: got %h want 1122aa44", rd); end
      access(0, 1'b1, WSTRB_HALF_HI, 32'h20, 32'hBBBB0000, rc, sh, rd, err);
      access(0, 1'b0, 4'h0, 32'h20, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rd !== 32'hBBBBAA44) begin n_fail++; $display("FAIL lane_half_hi: got %h want bbbbaa44", rd); end
      access(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, rc, sh, rd, err);
      n_cmp++; if (rc !== 4) begin n_fail++; $display("FAIL lane_zero_lat: got %0d want 4", rc); end
      access(0, 1'b0, 4'h0, 32'h20, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rd !== 32'hBBBBAA44) begin n_fail++; $display("FAIL lane_zero_data: got %h want bbbbaa44", rd); end
   endtask

   task automatic test_wait0();
      int rc; logic [15:0] sh; logic [31:0] rd; logic err;
      access(1, 1'b1, WSTRB_WORD, 32'h8, 32'h0BADCAFE, rc, sh, rd, err);
      access(1, 1'b0, 4'h0, 32'h8, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rc !== 2) begin n_fail++; $display("FAIL w0_lat: got %0d want 2", rc); end
      n_cmp++; if (sh !== 16'h0003) begin n_fail++; $display("FAIL w0_stall: got %h want 0003", sh); end
      n_cmp++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL w0_data: got %h want 0badcafe", rd); end
   endtask

   task automatic test_oob();
      int rc; logic [15:0] sh; logic [31:0] rd; logic err;
      access(0, 1'b1, WSTRB_WORD, 32'h0, 32'h600D0000, rc, sh, rd, err);
      access(0, 1'b1, WSTRB_WORD, 32'h1000, 32'hCAFEF00D, rc, sh, rd, err);
      n_cmp++; if (rc !== 4 || err !== 1'b1) begin
         n_fail++; $display("FAIL oob_st: got lat %0d err %b want 4 1", rc, err); end
      access(0, 1'b0, 4'h0, 32'h0, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rd !== 32'h600D0000 || err !== 1'b0) begin
         n_fail++; $display("FAIL oob_word0: got %h err %b want 600d0000 0", rd, err); end
      access(0, 1'b0, 4'h0, 32'h1000, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rd !== 32'h0 || err !== 1'b1) begin
         n_fail++; $display("FAIL oob_ld: got %h err %b want 0 1", rd, err); end
      access(0, 1'b1, WSTRB_WORD, 32'hFFC, 32'h12345678, rc, sh, rd, err);
      access(0, 1'b0, 4'h0, 32'hFFC, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rd !== 32'h12345678 || err !== 1'b0) begin
         n_fail++; $display("FAIL last_word: got %h err %b want 12345678 0", rd, err); end
   endtask

   task automatic test_reset_mid();
      int rc; logic [15:0] sh; logic [31:0] rd; logic err;
      access(0, 1'b1, WSTRB_WORD, 32'h40, 32'h01020304, rc, sh, rd, err);
      access(0, 1'b0, 4'h0, 32'h10, 32'h0, rc, sh, rd, err);
      req_we = 1'b1; req_wstrb = WSTRB_WORD; req_addr = 32'h40; req_wdata = 32'h5A5A5A5A;
      req_en_a = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0; #1;
      n_cmp++; if (stall_a !== 1'b0 || resp_valid_a !== 1'b0 || addr_err_a !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_ctl: got %b%b%b want 000", stall_a, resp_valid_a, addr_err_a); end
      n_cmp++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rdata: got %h want 0", rdata_a); end
      req_en_a = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      access(0, 1'b0, 4'h0, 32'h40, 32'h0, rc, sh, rd, err);
      n_cmp++; if (rc !== 4 || rd !== 32'h01020304) begin
         n_fail++; $display("FAIL mid_rst_keep: got lat %0d data %h want 4 01020304", rc, rd); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] rh, sh; logic [31:0] r1, r2; int cnt;
      rh = '0; sh = '0; r1 = '0; r2 = '0; cnt = 0;
      req_we = 1'b0; req_wstrb = '0; req_addr = 32'h10; req_wdata = '0; req_en_a = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         rh[k] = resp_valid_a;
         sh[k] = stall_a;
         if (resp_valid_a) begin
            if (cnt == 0) r1 = rdata_a; else r2 = rdata_a;
            cnt++;
         end
         @(posedge clk); #1;
         if (k == 4) req_addr = 32'h20;
      end
      req_en_a = 1'b0;
      n_cmp++; if (rh !== 10'h210) begin n_fail++; $display("FAIL b2b_resp: got %h want 210", rh); end
      n_cmp++; if (sh !== 10'h1EF) begin n_fail++; $display("FAIL b2b_stall: got %h want 1ef", sh); end
      n_cmp++; if (r1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_d1: got %h want deadbeef", r1); end
      n_cmp++; if (r2 !== 32'hBBBBAA44) begin n_fail++; $display("FAIL b2b_d2: got %h want bbbbaa44", r2); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_lanes();
      test_wait0();
      test_oob();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
